mem_arbiter: RTL and testbench

- Shares the single memory-bus port between the instruction-fetch requester and the data load/store requester.
- Grants one owner at a time, latches that owner's command, and drives the bus until the bus stops reporting full.
- Returns one-cycle ack/read-data to the owner, or an error on timeout.
- Sits between the CPU fetch/LSU stages and the memory controller's bus side.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arbiter_timer.sv | 43 ++++
 rtl/mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the memory-bus arbiter
// Contents: state_t (FSM encoding), owner_t (granted requester), default
// STARVE_MAX / TIMEOUT values.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int unsigned STARVE_MAX_DEF = 3;
    localparam int unsigned TIMEOUT_DEF    = 255;

endpackage

// File: rtl/mem_arbiter_timer.sv
// rtl/mem_arbiter_timer.sv - 8-bit loadable wait counter with limit detect
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr_i        force count to 0 (highest priority)
//   load_i       load count with 1 (first busy cycle already seen)
//   en_i         increment count
//   hit_o        count equals LIMIT
module arb_timer #(
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic load_i,
    input  logic en_i,
    output logic hit_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (load_i) begin
            cnt_d = 8'd1;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates one memory-bus port between fetch and load/store
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   i_req/i_addr                  fetch request (held until i_ack), address
//   i_ack/i_rdata                 one-cycle fetch completion, fetched word
//   d_req/d_we/d_addr/d_wdata     data request (held until d_ack), command
//   d_ack/d_rdata                 one-cycle data completion, load data
//   err                           pulses with the ack of a timed-out transaction
//   bus_req/bus_we/bus_addr/bus_wdata  bus command, held while bus_full
//   bus_rdata/bus_full            bus read data, bus busy
//   state                         current FSM state (debug)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_full,
    output logic [2:0]        state
);

    localparam logic [7:0] SMAX = 8'(STARVE_MAX);
    localparam logic [7:0] TMAX = 8'(TIMEOUT);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        starve_q, starve_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              tmr_clr;
    logic              tmr_load;
    logic              tmr_en;
    logic              tmr_hit;
    logic              grant_d;
    logic [DATA_W-1:0] cap_data;

    arb_timer #(
        .LIMIT (TMAX)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst),
        .clr_i  (tmr_clr),
        .load_i (tmr_load),
        .en_i   (tmr_en),
        .hit_o  (tmr_hit)
    );

    // Writes return nothing useful on the bus, so they report zero data.
    assign cap_data = we_q ? '0 : bus_rdata;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        starve_d  = starve_q;
        err_d     = err_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        tmr_clr   = 1'b0;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        grant_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    // Data wins ties until the fetch side has been passed over
                    // STARVE_MAX times in a row.
                    grant_d = d_req && !(i_req && (starve_q == SMAX));
                    if (grant_d) begin
                        owner_d = OWN_D;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        we_d    = d_we;
                        if (i_req && (starve_q != SMAX)) begin
                            starve_d = starve_q + 8'd1;
                        end
                    end else begin
                        owner_d  = OWN_I;
                        addr_d   = i_addr;
                        wdata_d  = '0;
                        we_d     = 1'b0;
                        starve_d = 8'd0;
                    end
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                if (!bus_full) begin
                    if (owner_q == OWN_D) d_rdata_d = cap_data;
                    else                  i_rdata_d = cap_data;
                    state_d = DONE;
                end else begin
                    tmr_load = 1'b1;
                    state_d  = WAIT;
                end
            end

            WAIT: begin
                if (!bus_full) begin
                    if (owner_q == OWN_D) d_rdata_d = cap_data;
                    else                  i_rdata_d = cap_data;
                    state_d = DONE;
                end else if (tmr_hit) begin
                    if (owner_q == OWN_D) d_rdata_d = '0;
                    else                  i_rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            DONE: begin
                err_d    = 1'b0;
                tmr_clr  = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                err_d   = 1'b0;
                tmr_clr = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            starve_q  <= 8'd0;
            err_q     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            starve_q  <= starve_d;
            err_q     <= err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Bus command is a pure decode of the state register so it drops the
    // instant reset asserts.
    assign bus_req   = (state_q == ISSUE) || (state_q == WAIT);
    assign bus_we    = bus_req && we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

    assign i_ack   = (state_q == DONE) && (owner_q == OWN_I);
    assign d_ack   = (state_q == DONE) && (owner_q == OWN_D);
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign err     = err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_full;
    logic [2:0]  state;

    typedef struct packed {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (3),
        .TIMEOUT    (255)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .err       (err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_full  (bus_full),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_ack(input int max_cyc, output int cyc, output logic got_i,
                            output logic got_d, output logic [31:0] ir,
                            output logic [31:0] dr, output logic e);
        cyc = 0; got_i = 1'b0; got_d = 1'b0; ir = '0; dr = '0; e = 1'b0;
        while (cyc < max_cyc && !(got_i || got_d)) begin
            @(negedge clk);
            cyc++;
            got_i = i_ack; got_d = d_ack; ir = i_rdata; dr = d_rdata; e = err;
        end
    endtask

    task automatic test_reset();
        exp_t ex; int cyc; logic gi, gd, e; logic [31:0] ir, dr;
        @(negedge clk);
        rst = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; bus_rdata = 32'h1234; bus_full = 1'b0;
        #1;
        vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL reset_state got=%0d exp=0", state); end
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL reset_bus_req got=%b exp=0", bus_req); end
        vectors++; if ({i_ack, d_ack, err} !== 3'b000) begin miscompares++; $display("FAIL reset_acks got=%b exp=000", {i_ack, d_ack, err}); end
        vectors++; if (d_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_d_rdata got=%h exp=0", d_rdata); end
        @(negedge clk);
        rst = 1'b1;
        ex.is_d = 1'b1; ex.rdata = 32'h1234; ex.err = 1'b0; sb.push_back(ex);
        @(negedge clk);
        vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL reset_release_state got=%0d exp=1", state); end
        wait_ack(5, cyc, gi, gd, ir, dr, e);
        d_req = 1'b0;
        ex = sb.pop_front();
        vectors++; if ({gi, gd, dr, e} !== {~ex.is_d, ex.is_d, ex.rdata, ex.err}) begin miscompares++; $display("FAIL reset_first_txn got=%b%b %h %b exp=%b%b %h %b", gi, gd, dr, e, ~ex.is_d, ex.is_d, ex.rdata, ex.err); end
    endtask

    task automatic test_data_read();
        exp_t ex; int cyc; logic gi, gd, e; logic [31:0] ir, dr;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; bus_full = 1'b0; bus_rdata = 32'hDEAD;
        ex.is_d = 1'b1; ex.rdata = 32'hDEAD; ex.err = 1'b0; sb.push_back(ex);
        @(negedge clk);
        vectors++; if ({state, bus_req, bus_we, bus_addr} !== {3'd1, 1'b1, 1'b0, 32'h10}) begin miscompares++; $display("FAIL read_issue got=%0d %b %b %h exp=1 1 0 00000010", state, bus_req, bus_we, bus_addr); end
        wait_ack(5, cyc, gi, gd, ir, dr, e);
        d_req = 1'b0;
        ex = sb.pop_front();
        vectors++; if (cyc !== 1) begin miscompares++; $display("FAIL read_latency got=%0d exp=1 after issue", cyc); end
        vectors++; if ({gi, gd, dr, e} !== {~ex.is_d, ex.is_d, ex.rdata, ex.err}) begin miscompares++; $display("FAIL read_ack got=%b%b %h %b exp=%b%b %h %b", gi, gd, dr, e, ~ex.is_d, ex.is_d, ex.rdata, ex.err); end
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL read_done_bus_req got=%b exp=0", bus_req); end
        @(negedge clk);
        vectors++; if ({state, d_ack, d_rdata} !== {3'd0, 1'b0, 32'hDEAD}) begin miscompares++; $display("FAIL read_hold got=%0d %b %h exp=0 0 0000dead", state, d_ack, d_rdata); end
    endtask

    task automatic test_write_busy();
        exp_t ex; int cyc; logic gi, gd, e; logic [31:0] ir, dr;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h55; bus_full = 1'b1; bus_rdata = 32'hCAFE;
        ex.is_d = 1'b1; ex.rdata = 32'h0; ex.err = 1'b0; sb.push_back(ex);
        @(negedge clk);
        vectors++; if ({state, bus_we} !== {3'd1, 1'b1}) begin miscompares++; $display("FAIL write_issue got=%0d %b exp=1 1", state, bus_we); end
        d_wdata = 32'hFF; d_addr = 32'h99; d_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if ({state, bus_req, bus_we, bus_addr, bus_wdata} !== {3'd2, 1'b1, 1'b1, 32'h20, 32'h55}) begin miscompares++; $display("FAIL write_wait%0d got=%0d %b %b %h %h exp=2 1 1 00000020 00000055", i, state, bus_req, bus_we, bus_addr, bus_wdata); end
            if (i == 2) bus_full = 1'b0;
        end
        wait_ack(5, cyc, gi, gd, ir, dr, e);
        d_req = 1'b0;
        ex = sb.pop_front();
        vectors++; if (cyc !== 1) begin miscompares++; $display("FAIL write_latency got=%0d exp=1", cyc); end
        vectors++; if ({gi, gd, dr, e} !== {~ex.is_d, ex.is_d, ex.rdata, ex.err}) begin miscompares++; $display("FAIL write_ack got=%b%b %h %b exp=%b%b %h %b", gi, gd, dr, e, ~ex.is_d, ex.is_d, ex.rdata, ex.err); end
    endtask

    task automatic test_arbitration();
        exp_t ex; int cyc; logic gi, gd, e; logic [31:0] ir, dr, rd;
        int starve;
        starve = 0;
        @(negedge clk);
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h100; d_addr = 32'h200; d_we = 1'b0; bus_full = 1'b0;
        for (int n = 0; n < 8; n++) begin
            bus_rdata = 32'h1000 + n;
            ex.is_d = (starve != 3); ex.rdata = 32'h1000 + n; ex.err = 1'b0;
            starve = ex.is_d ? starve + 1 : 0;
            sb.push_back(ex);
            wait_ack(10, cyc, gi, gd, ir, dr, e);
            if (n == 7) begin i_req = 1'b0; d_req = 1'b0; end
            ex = sb.pop_front();
            rd = ex.is_d ? dr : ir;
            vectors++; if ({gi, gd} !== {~ex.is_d, ex.is_d}) begin miscompares++; $display("FAIL arb_grant%0d got i=%b d=%b exp i=%b d=%b", n, gi, gd, ~ex.is_d, ex.is_d); end
            vectors++; if (rd !== ex.rdata) begin miscompares++; $display("FAIL arb_rdata%0d got=%h exp=%h", n, rd, ex.rdata); end
        end
    endtask

    task automatic test_timeout();
        exp_t ex; int cyc; logic gi, gd, e; logic [31:0] ir, dr;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30; bus_full = 1'b1; bus_rdata = 32'hBEEF;
        ex.is_d = 1'b1; ex.rdata = 32'h0; ex.err = 1'b1; sb.push_back(ex);
        wait_ack(400, cyc, gi, gd, ir, dr, e);
        d_req = 1'b0;
        ex = sb.pop_front();
        vectors++; if (cyc !== 257) begin miscompares++; $display("FAIL timeout_cycles got=%0d exp=257", cyc); end
        vectors++; if ({gi, gd, dr, e} !== {~ex.is_d, ex.is_d, ex.rdata, ex.err}) begin miscompares++; $display("FAIL timeout_ack got=%b%b %h %b exp=%b%b %h %b", gi, gd, dr, e, ~ex.is_d, ex.is_d, ex.rdata, ex.err); end
        @(negedge clk);
        bus_full = 1'b0;
        vectors++; if ({state, err, bus_req} !== {3'd0, 1'b0, 1'b0}) begin miscompares++; $display("FAIL timeout_idle got=%0d %b %b exp=0 0 0", state, err, bus_req); end
    endtask

    task automatic test_midop();
        exp_t ex; int cyc; int acks; logic gi, gd, e; logic [31:0] ir, dr;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h40; d_we = 1'b1; bus_full = 1'b1; bus_rdata = 32'h77;
        ex.is_d = 1'b0; ex.rdata = 32'h77; ex.err = 1'b0; sb.push_back(ex);
        @(negedge clk);
        vectors++; if ({state, bus_we, bus_addr} !== {3'd1, 1'b0, 32'h40}) begin miscompares++; $display("FAIL instr_issue got=%0d %b %h exp=1 0 00000040", state, bus_we, bus_addr); end
        @(negedge clk);
        i_req = 1'b0;
        vectors++; if (state !== 3'd2) begin miscompares++; $display("FAIL instr_wait got=%0d exp=2", state); end
        @(negedge clk);
        bus_full = 1'b0;
        wait_ack(5, cyc, gi, gd, ir, dr, e);
        ex = sb.pop_front();
        vectors++; if ({gi, gd, ir, e} !== {~ex.is_d, ex.is_d, ex.rdata, ex.err}) begin miscompares++; $display("FAIL drop_req_ack got=%b%b %h %b exp=%b%b %h %b", gi, gd, ir, e, ~ex.is_d, ex.is_d, ex.rdata, ex.err); end
        @(negedge clk);
        vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL drop_req_idle got=%0d exp=0", state); end
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50; bus_full = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (state !== 3'd2) begin miscompares++; $display("FAIL rst_pre_wait got=%0d exp=2", state); end
        rst = 1'b0;
        #1;
        vectors++; if ({state, bus_req, d_ack, i_ack} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin miscompares++; $display("FAIL midop_reset got=%0d %b %b %b exp=0 0 0 0", state, bus_req, d_ack, i_ack); end
        d_req = 1'b0; bus_full = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (i_ack || d_ack) acks++;
        end
        vectors++; if (acks !== 0) begin miscompares++; $display("FAIL midop_no_ack got=%0d exp=0", acks); end
        vectors++; if (sb.size() !== 0) begin miscompares++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; bus_rdata = '0; bus_full = 1'b0;
        test_reset();
        test_data_read();
        test_write_busy();
        test_arbitration();
        test_timeout();
        test_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
